// File: rtl/window_feed_ctrl_if.sv
// Pixel-stream input, window-buffer feed and window-position outputs of window_feed_ctrl.
// Latency: none; this is a bundle of wires.
// Backpressure: inReady qualifies the upstream stream; window outputs have no ready.
interface window_feed_ctrl_if #(
    parameter int BW = 8,
    parameter int XW = 9,
    parameter int YW = 8
);
    logic          start;
    logic          inValid;
    logic [BW-1:0] inData;
    logic          inReady;
    logic          bufEnable;
    logic [BW-1:0] bufData;
    logic          winValid;
    logic [XW-1:0] winX;
    logic [YW-1:0] winY;
    logic          busy;
    logic          frameDone;

    // Frame source / observer side
    modport master (
        output start, inValid, inData,
        input  inReady, bufEnable, bufData, winValid, winX, winY, busy, frameDone
    );

    // Feeder side
    modport slave (
        input  start, inValid, inData,
        output inReady, bufEnable, bufData, winValid, winX, winY, busy, frameDone
    );
endinterface

// File: rtl/window_feed_ctrl.sv
// Feeds one frame of pixels into the window shift buffer and tags full-window shifts with position.
// Latency: accept -> bufEnable/bufData 1 cycle, accept -> winValid/winX/winY and frameDone 2 cycles.
// Backpressure: inReady only in FILL/RUN; the window consumer cannot stall and sees every pulse.
module window_feed_ctrl #(
    parameter int maxRow    = 35,
    parameter int maxCol    = 20,
    parameter int bitwidth  = 8,
    parameter int imgWidth  = 320,
    parameter int imgHeight = 240
) (
    input  logic               clock,
    input  logic               reset,
    window_feed_ctrl_if.slave  bus
);
    localparam int FILL = maxRow * maxCol;
    localparam int NPIX = imgWidth * imgHeight;
    localparam int FCW  = $clog2(FILL + 1);
    localparam int PCW  = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int XW   = (imgWidth > 1) ? $clog2(imgWidth) : 1;
    localparam int YW   = (imgHeight > 1) ? $clog2(imgHeight) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                r_state;
    logic [FCW-1:0]        r_fill_cnt;
    logic [PCW-1:0]        r_pix_cnt;
    logic [XW-1:0]         r_x;
    logic [YW-1:0]         r_y;

    // Stage 1: buffer feed plus the tag of the pixel being shifted in
    logic                  r_buf_en;
    logic [bitwidth-1:0]   r_buf_dat;
    logic                  r_s1_win;
    logic                  r_s1_last;
    logic [XW-1:0]         r_s1_x;
    logic [YW-1:0]         r_s1_y;

    // Stage 2: aligned with the buffer taps after the shift
    logic                  r_win_vld;
    logic [XW-1:0]         r_win_x;
    logic [YW-1:0]         r_win_y;
    logic                  r_frame_done;

    logic                  w_ready;
    logic                  w_acc;
    logic                  w_win;
    logic                  w_last;
    logic                  w_x_wrap;
    logic                  w_busy;

    assign w_ready  = (r_state == S_FILL) || (r_state == S_RUN);
    assign w_acc    = bus.inValid && w_ready;
    // The accept that brings the chain to FILL entries is the first full window
    assign w_win    = (r_fill_cnt >= FCW'(FILL - 1));
    assign w_last   = (r_pix_cnt == PCW'(NPIX - 1));
    assign w_x_wrap = (r_x == XW'(imgWidth - 1));
    // Busy covers the frameDone cycle so a new start cannot overlap the pulse
    assign w_busy   = (r_state != S_IDLE) || r_frame_done;

    // Frame FSM with fill, pixel and position counters
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_fill_cnt <= '0;
            r_pix_cnt  <= '0;
            r_x        <= '0;
            r_y        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start && !w_busy) begin
                        r_state    <= S_FILL;
                        r_fill_cnt <= '0;
                        r_pix_cnt  <= '0;
                        r_x        <= '0;
                        r_y        <= '0;
                    end
                end
                S_FILL, S_RUN: begin
                    if (w_acc) begin
                        if (r_fill_cnt != FCW'(FILL))
                            r_fill_cnt <= r_fill_cnt + FCW'(1);
                        r_pix_cnt <= r_pix_cnt + PCW'(1);
                        if (w_x_wrap) begin
                            r_x <= '0;
                            r_y <= r_y + YW'(1);
                        end else begin
                            r_x <= r_x + XW'(1);
                        end
                        if (w_last)
                            r_state <= S_DONE;
                        else if ((r_state == S_FILL) && (r_fill_cnt == FCW'(FILL - 1)))
                            r_state <= S_RUN;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Two-stage output pipeline: buffer shift, then window tag on the updated taps
    always_ff @(posedge clock) begin
        if (reset) begin
            r_buf_en     <= 1'b0;
            r_buf_dat    <= '0;
            r_s1_win     <= 1'b0;
            r_s1_last    <= 1'b0;
            r_s1_x       <= '0;
            r_s1_y       <= '0;
            r_win_vld    <= 1'b0;
            r_win_x      <= '0;
            r_win_y      <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_buf_en  <= w_acc;
            r_s1_win  <= w_acc && w_win;
            r_s1_last <= w_acc && w_last;
            if (w_acc) begin
                r_buf_dat <= bus.inData;
                r_s1_x    <= r_x;
                r_s1_y    <= r_y;
            end
            r_win_vld    <= r_s1_win;
            r_frame_done <= r_s1_last;
            if (r_s1_win) begin
                r_win_x <= r_s1_x;
                r_win_y <= r_s1_y;
            end
        end
    end

    assign bus.inReady   = w_ready;
    assign bus.bufEnable = r_buf_en;
    assign bus.bufData   = r_buf_dat;
    assign bus.winValid  = r_win_vld;
    assign bus.winX      = r_win_x;
    assign bus.winY      = r_win_y;
    assign bus.busy      = w_busy;
    assign bus.frameDone = r_frame_done;
endmodule

// File: tb/tb_window_feed_ctrl.sv
// Bench for window_feed_ctrl: a 4x3-window / 8x4-image instance and a 3x2-image instance.
// Scoreboard queues hold cycle-stamped expected buffer writes, window tags and frameDone.
// Inputs change #1 after the rising edge; outputs are sampled on the falling edge.
module tb_window_feed_ctrl;
    localparam int A_W    = 8;
    localparam int A_FILL = 12;
    localparam int A_NPIX = 32;

    typedef struct {int cyc; int dat;}      buf_exp_t;
    typedef struct {int cyc; int x; int y;} win_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    window_feed_ctrl_if #(.BW(8), .XW(3), .YW(2)) ia();
    window_feed_ctrl_if #(.BW(8), .XW(2), .YW(1)) ib();

    window_feed_ctrl #(.maxRow(4), .maxCol(3), .bitwidth(8), .imgWidth(8), .imgHeight(4))
        dut_a (.clock(clk), .reset(rst), .bus(ia));
    window_feed_ctrl #(.maxRow(4), .maxCol(3), .bitwidth(8), .imgWidth(3), .imgHeight(2))
        dut_b (.clock(clk), .reset(rst), .bus(ib));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;

    buf_exp_t q_buf[$];
    win_exp_t q_win[$];
    int       q_fd[$];
    buf_exp_t eb;
    win_exp_t ew;
    int       ef;
    int       idx;

    int a_acc, a_win_cnt, a_fd_cnt, a_first_be, a_first_wx, a_first_wy;
    int b_acc, b_win_cnt, b_fd_cnt, b_fd_cyc, b_last_acc;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard for instance A: compare produced outputs, then log this cycle's accept
    always @(negedge clk) begin
        if (mon_en) begin
            while (q_buf.size() > 0 && q_buf[0].cyc < cyc) begin
                n_checks++; n_fail++;
                $display("FAIL buf_missing cyc=%0d got no bufEnable, required data %0h at cyc %0d", cyc, q_buf[0].dat, q_buf[0].cyc);
                q_buf.delete(0);
            end
            if (ia.bufEnable) begin
                n_checks++;
                if (a_first_be < 0) a_first_be = cyc;
                if (q_buf.size() == 0) begin
                    n_fail++;
                    $display("FAIL buf_unexpected cyc=%0d got bufEnable=1 data=%0h, required bufEnable=0", cyc, ia.bufData);
                end else begin
                    eb = q_buf.pop_front();
                    if (eb.cyc != cyc || ia.bufData !== 8'(eb.dat)) begin
                        n_fail++;
                        $display("FAIL buf_data cyc=%0d got %0h, required %0h at cyc %0d", cyc, ia.bufData, eb.dat, eb.cyc);
                    end
                end
            end
            while (q_win.size() > 0 && q_win[0].cyc < cyc) begin
                n_checks++; n_fail++;
                $display("FAIL win_missing cyc=%0d got no winValid, required (%0d,%0d) at cyc %0d", cyc, q_win[0].x, q_win[0].y, q_win[0].cyc);
                q_win.delete(0);
            end
            if (ia.winValid) begin
                n_checks++;
                a_win_cnt++;
                if (a_first_wx < 0) begin
                    a_first_wx = int'(ia.winX);
                    a_first_wy = int'(ia.winY);
                end
                if (q_win.size() == 0) begin
                    n_fail++;
                    $display("FAIL win_unexpected cyc=%0d got winValid at (%0d,%0d), required winValid=0", cyc, ia.winX, ia.winY);
                end else begin
                    ew = q_win.pop_front();
                    if (ew.cyc != cyc || ia.winX !== 3'(ew.x) || ia.winY !== 2'(ew.y)) begin
                        n_fail++;
                        $display("FAIL win_pos cyc=%0d got (%0d,%0d), required (%0d,%0d) at cyc %0d", cyc, ia.winX, ia.winY, ew.x, ew.y, ew.cyc);
                    end
                end
            end
            while (q_fd.size() > 0 && q_fd[0] < cyc) begin
                n_checks++; n_fail++;
                $display("FAIL fd_missing cyc=%0d got no frameDone, required at cyc %0d", cyc, q_fd[0]);
                q_fd.delete(0);
            end
            if (ia.frameDone) begin
                n_checks++;
                a_fd_cnt++;
                if (q_fd.size() == 0) begin
                    n_fail++;
                    $display("FAIL fd_unexpected cyc=%0d got frameDone=1, required 0", cyc);
                end else begin
                    ef = q_fd.pop_front();
                    if (ef != cyc) begin
                        n_fail++;
                        $display("FAIL fd_time got frameDone at cyc %0d, required cyc %0d", cyc, ef);
                    end
                end
            end
            if (ia.inValid && ia.inReady) begin
                idx = a_acc;
                a_acc++;
                q_buf.push_back('{cyc + 1, int'(ia.inData)});
                if (a_acc >= A_FILL) q_win.push_back('{cyc + 2, idx % A_W, idx / A_W});
                if (a_acc == A_NPIX) q_fd.push_back(cyc + 2);
            end
        end
    end

    // Event recorder for instance B
    always @(negedge clk) begin
        if (mon_en) begin
            if (ib.winValid) b_win_cnt++;
            if (ib.frameDone) begin
                b_fd_cnt++;
                b_fd_cyc = cyc;
            end
            if (ib.inValid && ib.inReady) begin
                b_acc++;
                b_last_acc = cyc;
            end
        end
    end

    task automatic clear_a();
        a_acc = 0; a_win_cnt = 0; a_fd_cnt = 0;
        a_first_be = -1; a_first_wx = -1; a_first_wy = -1;
    endtask

    task automatic pulse_start_a(output int s);
        @(posedge clk); #1;
        ia.start = 1'b1;
        s = cyc;
    endtask

    // Stream pixels into A until frameDone, stop_acc accepts, or the cycle budget runs out
    task automatic drive_frame_a(input bit toggle, input int restart_at, input int stop_acc, output bit got_fd);
        got_fd = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            ia.start   = (k == restart_at);
            ia.inValid = toggle ? (k % 2 == 0) : 1'b1;
            ia.inData  = 8'($urandom);
            @(negedge clk); #1;
            if (ia.frameDone) begin
                got_fd = 1'b1;
                break;
            end
            if (stop_acc > 0 && a_acc >= stop_acc) break;
        end
        ia.inValid = 1'b0;
        ia.start   = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk); #1;
        n_checks++; if (ia.inReady !== 1'b0)   begin n_fail++; $display("FAIL reset_inReady got %b, required 0", ia.inReady); end
        n_checks++; if (ia.bufEnable !== 1'b0) begin n_fail++; $display("FAIL reset_bufEnable got %b, required 0", ia.bufEnable); end
        n_checks++; if (ia.bufData !== 8'h00)  begin n_fail++; $display("FAIL reset_bufData got %h, required 00", ia.bufData); end
        n_checks++; if (ia.winValid !== 1'b0)  begin n_fail++; $display("FAIL reset_winValid got %b, required 0", ia.winValid); end
        n_checks++; if ({ia.winX, ia.winY} !== 5'd0) begin n_fail++; $display("FAIL reset_winXY got (%0d,%0d), required (0,0)", ia.winX, ia.winY); end
        n_checks++; if (ia.busy !== 1'b0 || ia.frameDone !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done got busy=%b done=%b, required 0 0", ia.busy, ia.frameDone); end
        n_checks++; if (ib.inReady !== 1'b0 || ib.busy !== 1'b0) begin n_fail++; $display("FAIL reset_b got inReady=%b busy=%b, required 0 0", ib.inReady, ib.busy); end
        mon_en = 1'b1;
    endtask

    task automatic test_continuous();
        int s; bit got;
        clear_a();
        pulse_start_a(s);
        drive_frame_a(1'b0, -1, 0, got);
        n_checks++; if (got !== 1'b1)     begin n_fail++; $display("FAIL cont_timeout got frameDone=%b, required 1", got); end
        n_checks++; if (a_first_be != s + 2) begin n_fail++; $display("FAIL cont_first_be got cyc %0d, required %0d", a_first_be, s + 2); end
        n_checks++; if (a_acc != A_NPIX)  begin n_fail++; $display("FAIL cont_accepts got %0d, required %0d", a_acc, A_NPIX); end
        n_checks++; if (a_win_cnt != 21) begin n_fail++; $display("FAIL cont_win_count got %0d, required 21", a_win_cnt); end
        n_checks++; if (a_first_wx != 3 || a_first_wy != 1) begin n_fail++; $display("FAIL cont_first_win got (%0d,%0d), required (3,1)", a_first_wx, a_first_wy); end
        n_checks++; if (ia.busy !== 1'b1) begin n_fail++; $display("FAIL cont_busy_at_done got %b, required 1", ia.busy); end
        @(negedge clk); #1;
        n_checks++; if (ia.busy !== 1'b0 || ia.inReady !== 1'b0) begin n_fail++; $display("FAIL cont_busy_after got busy=%b inReady=%b, required 0 0", ia.busy, ia.inReady); end
        n_checks++; if (q_buf.size() + q_win.size() + q_fd.size() != 0) begin n_fail++; $display("FAIL cont_leftover got %0d pending, required 0", q_buf.size() + q_win.size() + q_fd.size()); end
    endtask

    task automatic test_toggle();
        int s; bit got;
        clear_a();
        pulse_start_a(s);
        drive_frame_a(1'b1, -1, 0, got);
        n_checks++; if (got !== 1'b1)    begin n_fail++; $display("FAIL tog_timeout got frameDone=%b, required 1", got); end
        n_checks++; if (a_acc != A_NPIX) begin n_fail++; $display("FAIL tog_accepts got %0d, required %0d", a_acc, A_NPIX); end
        n_checks++; if (a_win_cnt != 21) begin n_fail++; $display("FAIL tog_win_count got %0d, required 21", a_win_cnt); end
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (ia.winX !== 3'd7 || ia.winY !== 2'd3) begin n_fail++; $display("FAIL tog_win_hold got (%0d,%0d), required (7,3)", ia.winX, ia.winY); end
    endtask

    task automatic test_small_frame();
        b_acc = 0; b_win_cnt = 0; b_fd_cnt = 0; b_fd_cyc = -1; b_last_acc = -1;
        @(posedge clk); #1;
        ib.start = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            ib.start   = 1'b0;
            ib.inValid = 1'b1;
            ib.inData  = 8'($urandom);
            @(negedge clk); #1;
            if (b_fd_cnt > 0) break;
        end
        ib.inValid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        n_checks++; if (b_acc != 6)      begin n_fail++; $display("FAIL small_accepts got %0d, required 6", b_acc); end
        n_checks++; if (b_win_cnt != 0)  begin n_fail++; $display("FAIL small_winValid got %0d pulses, required 0", b_win_cnt); end
        n_checks++; if (b_fd_cnt != 1)   begin n_fail++; $display("FAIL small_fd_count got %0d, required 1", b_fd_cnt); end
        n_checks++; if (b_fd_cyc != b_last_acc + 2) begin n_fail++; $display("FAIL small_fd_time got cyc %0d, required %0d", b_fd_cyc, b_last_acc + 2); end
    endtask

    task automatic test_start_ignored();
        int s; bit got;
        clear_a();
        @(posedge clk); #1;
        ia.start   = 1'b1;
        ia.inValid = 1'b1;
        ia.inData  = 8'hA5;
        s = cyc;
        @(negedge clk); #1;
        n_checks++; if (ia.inReady !== 1'b0) begin n_fail++; $display("FAIL idle_inReady got %b, required 0", ia.inReady); end
        drive_frame_a(1'b0, 10, 0, got);
        n_checks++; if (got !== 1'b1)    begin n_fail++; $display("FAIL ign_timeout got frameDone=%b, required 1", got); end
        n_checks++; if (a_first_be != s + 2) begin n_fail++; $display("FAIL ign_first_be got cyc %0d, required %0d", a_first_be, s + 2); end
        n_checks++; if (a_acc != A_NPIX) begin n_fail++; $display("FAIL ign_accepts got %0d, required %0d", a_acc, A_NPIX); end
        n_checks++; if (a_win_cnt != 21) begin n_fail++; $display("FAIL ign_win_count got %0d, required 21", a_win_cnt); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        int s; bit got;
        clear_a();
        pulse_start_a(s);
        drive_frame_a(1'b0, -1, 10, got);
        n_checks++; if (a_acc != 10 || got !== 1'b0) begin n_fail++; $display("FAIL rst_pre got accepts=%0d done=%b, required 10 0", a_acc, got); end
        @(posedge clk); #1;
        rst = 1'b1;
        mon_en = 1'b0;
        q_buf.delete(); q_win.delete(); q_fd.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        n_checks++; if (ia.bufEnable !== 1'b0 || ia.bufData !== 8'h00) begin n_fail++; $display("FAIL rst_buf got en=%b data=%h, required 0 00", ia.bufEnable, ia.bufData); end
        n_checks++; if (ia.inReady !== 1'b0 || ia.busy !== 1'b0) begin n_fail++; $display("FAIL rst_state got inReady=%b busy=%b, required 0 0", ia.inReady, ia.busy); end
        n_checks++; if (ia.winValid !== 1'b0 || ia.frameDone !== 1'b0) begin n_fail++; $display("FAIL rst_pulses got win=%b done=%b, required 0 0", ia.winValid, ia.frameDone); end
        mon_en = 1'b1;
        clear_a();
        pulse_start_a(s);
        drive_frame_a(1'b0, -1, 0, got);
        n_checks++; if (got !== 1'b1)    begin n_fail++; $display("FAIL rst_refill_timeout got frameDone=%b, required 1", got); end
        n_checks++; if (a_win_cnt != 21) begin n_fail++; $display("FAIL rst_refill_win_count got %0d, required 21", a_win_cnt); end
        n_checks++; if (a_first_wx != 3 || a_first_wy != 1) begin n_fail++; $display("FAIL rst_refill_first_win got (%0d,%0d), required (3,1)", a_first_wx, a_first_wy); end
    endtask

    task automatic test_back_to_back();
        int s1, s2, fd1; bit got;
        clear_a();
        pulse_start_a(s1);
        drive_frame_a(1'b0, -1, 0, got);
        fd1 = cyc;
        n_checks++; if (got !== 1'b1 || a_acc != A_NPIX) begin n_fail++; $display("FAIL b2b_frame1 got done=%b accepts=%0d, required 1 %0d", got, a_acc, A_NPIX); end
        clear_a();
        pulse_start_a(s2);
        drive_frame_a(1'b0, -1, 0, got);
        n_checks++; if (s2 != fd1 + 1)   begin n_fail++; $display("FAIL b2b_start_cyc got %0d, required %0d", s2, fd1 + 1); end
        n_checks++; if (got !== 1'b1)    begin n_fail++; $display("FAIL b2b_timeout got frameDone=%b, required 1", got); end
        n_checks++; if (a_first_be != s2 + 2) begin n_fail++; $display("FAIL b2b_first_be got cyc %0d, required %0d", a_first_be, s2 + 2); end
        n_checks++; if (a_win_cnt != 21) begin n_fail++; $display("FAIL b2b_win_count got %0d, required 21", a_win_cnt); end
        n_checks++; if (a_first_wx != 3 || a_first_wy != 1) begin n_fail++; $display("FAIL b2b_first_win got (%0d,%0d), required (3,1)", a_first_wx, a_first_wy); end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        ia.start = 1'b0; ia.inValid = 1'b0; ia.inData = '0;
        ib.start = 1'b0; ib.inValid = 1'b0; ib.inData = '0;
        test_reset();
        test_continuous();
        test_toggle();
        test_small_frame();
        test_start_ignored();
        test_reset_mid_frame();
        test_back_to_back();
        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete within time limit");
        $fatal(1);
    end
endmodule
